udp_mode_rx: RTL and testbench
==============================

# udp_mode_rx

Mother-board receiver for the 2-byte mode-switch command carried in a UDP payload. It sits after the UDP stack's receive application interface. It assembles the payload big-endian and validates length and value. On a valid command it latches the new mode (camera 0x0001 / SD card 0x0003) and pulses an update strobe; any malformed packet is dropped with an error pulse.

## Interface
Parameters:
- CMD_LEN, 2: required payload length in bytes.
- MODE_CAM, 16'h0001: camera-mode command value.
- MODE_SD, 16'h0003: SD-card-mode command value.
- INIT_MODE, 16'h0001: mode held after reset.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- app_rx_data_valid  in  1  payload byte strobe; high for each payload byte, contiguous within a packet.
- app_rx_data  in  8  payload byte; first byte is the command MSB.
- app_rx_data_length  in  16  UDP payload length; valid with the first byte of a packet.
- mode_cmd  out  16  currently active mode command.
- cam_en  out  1  high when mode_cmd == MODE_CAM.
- sd_en  out  1  high when mode_cmd == MODE_SD.
- mode_update  out  1  one-cycle pulse when a valid command is accepted.
- cmd_err  out  1  one-cycle pulse when a packet is rejected.
- busy  out  1  high while a packet is being collected or checked.
- rx_ok_cnt  out  16  count of accepted commands (see Configuration).
- rx_err_cnt  out  16  count of rejected packets (see Configuration).

## Operation
- States: IDLE, RECV, CHECK.
- IDLE: on valid=1, capture the byte into cmd_shift[7:0], set byte_cnt=1, latch app_rx_data_length into len_q, then go to RECV.
- RECV:
  - valid=1: cmd_shift <= {cmd_shift[7:0], app_rx_data} and byte_cnt++. byte_cnt saturates at 16'hFFFF.
  - valid=0: end of packet; go to CHECK.
- CHECK (one cycle): a packet is accepted when byte_cnt == CMD_LEN, len_q == CMD_LEN, and cmd_shift ∈ {MODE_CAM, MODE_SD}.
  - Accept: mode_cmd <= cmd_shift, pulse mode_update.
  - Otherwise: mode_cmd is unchanged, pulse cmd_err.
  - Next state is IDLE, or RECV if valid=1 in this cycle.
- Back-to-back packets: when valid=1 during CHECK, that byte starts a new packet exactly as in IDLE, so no byte is lost.
- Re-sending the current mode is accepted: mode_update pulses and mode_cmd keeps the same value.
- Short packets (1 byte), long packets (≥3 bytes), a length-field mismatch, and unknown values (0x0000, 0x0002, 0xFFFF) are all rejected.
- cam_en and sd_en are registered and follow mode_cmd in the same cycle it updates.
- busy = (state != IDLE).

## Timing
- Reset values:
  - mode_cmd = INIT_MODE.
  - cam_en = 1 and sd_en = 0 for the default INIT_MODE.
  - mode_update, cmd_err, busy = 0.
  - rx_ok_cnt and rx_err_cnt = 0.
  - state = IDLE.
- Latency: the last payload byte is sampled at edge E. Edge E+1 samples valid=0 and enters CHECK. Edge E+2 registers mode_cmd, cam_en, sd_en, and the mode_update or cmd_err pulse. mode_update and cmd_err are high for exactly the cycle after E+2.
- A packet needs at least one valid-low cycle after its last byte to be checked.
- Reset asserted mid-packet: the partial packet is discarded with no pulse, and mode_cmd returns to INIT_MODE.
- No backpressure: every valid byte is consumed on the cycle it is presented.

## Configuration
- MODE_RX_STATS_EN defined:
  - rx_ok_cnt increments on each mode_update.
  - rx_err_cnt increments on each cmd_err.
  - Both are 16-bit, wrap at 16'hFFFF → 0, and are updated on the same edge as the pulse.
- Not defined: both counters are tied to 16'd0 and no counter logic is built.

## Structure
- Shared package udp_mode_pkg holds:
  - MODE_CAM and MODE_SD values, shared with the key-triggered transmitter.
  - Command length 2.
  - State encoding of the receiver FSM.
- No sub-module. The byte shift, counter, and FSM are small enough for a single module.

## Test plan
- Bytes 0x00,0x01, length=2, then valid low → mode_update pulses at E+2; mode_cmd=0x0001, cam_en=1, sd_en=0.
- Bytes 0x00,0x03, length=2 → mode_cmd=0x0003, sd_en=1, cam_en=0; with the macro defined, rx_ok_cnt=1.
- Malformed packets, each followed by valid low, each give a cmd_err pulse, unchanged mode_cmd, and with the macro defined, an rx_err_cnt increment:
  - 1-byte 0x00.
  - 3-byte 0x00,0x03,0x00.
  - Bytes 0x00,0x02.
  - Length field=4 with 2 bytes.
- Packet 0x00,0x03, one idle cycle, then 0x00,0x01 with its first byte arriving during CHECK → two mode_update pulses; final mode_cmd=0x0001.
- rst_n low after the first byte of 0x00,0x03, released, then valid low → no pulse; mode_cmd=0x0001 (INIT_MODE); busy=0.

Source files
------------

// File: rtl/udp_mode_pkg.sv
// udp_mode_pkg: constants shared by the UDP mode-switch receiver and the
// key-triggered transmitter (command values, command length) plus the
// receiver FSM state encoding.
package udp_mode_pkg;

    localparam logic [15:0] PKG_MODE_CAM = 16'h0001;
    localparam logic [15:0] PKG_MODE_SD  = 16'h0003;
    localparam logic [15:0] PKG_CMD_LEN  = 16'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // True when the assembled payload is one of the two known mode commands.
    function automatic logic is_known_mode(input logic [15:0] value,
                                           input logic [15:0] cam_val,
                                           input logic [15:0] sd_val);
        return (value == cam_val) || (value == sd_val);
    endfunction

endpackage

// File: rtl/udp_mode_rx_if.sv
// udp_mode_rx_if: receive application interface of the UDP stack
// (payload byte strobe, byte, and payload length).
interface udp_mode_rx_if;

    logic        app_rx_data_valid;
    logic [7:0]  app_rx_data;
    logic [15:0] app_rx_data_length;

    modport master (
        output app_rx_data_valid,
        output app_rx_data,
        output app_rx_data_length
    );

    modport slave (
        input app_rx_data_valid,
        input app_rx_data,
        input app_rx_data_length
    );

endinterface

// File: rtl/udp_mode_rx.sv
// udp_mode_rx: assembles a 2-byte big-endian mode-switch command from the
// UDP payload stream, validates byte count, length field and value, then
// latches the new mode with an update strobe or drops it with an error pulse.
// Optional accept/reject statistics counters: define MODE_RX_STATS_EN.
module udp_mode_rx
    import udp_mode_pkg::*;
#(
    parameter logic [15:0] CMD_LEN   = PKG_CMD_LEN,
    parameter logic [15:0] MODE_CAM  = PKG_MODE_CAM,
    parameter logic [15:0] MODE_SD   = PKG_MODE_SD,
    parameter logic [15:0] INIT_MODE = PKG_MODE_CAM
) (
    input  logic          clk,
    input  logic          rst_n,
    udp_mode_rx_if.slave  rx,
    output logic [15:0]   mode_cmd,
    output logic          cam_en,
    output logic          sd_en,
    output logic          mode_update,
    output logic          cmd_err,
    output logic          busy,
    output logic [15:0]   rx_ok_cnt,
    output logic [15:0]   rx_err_cnt
);

    logic [1:0]  r_state;
    logic [15:0] r_cmd_shift;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_len_q;
    logic [15:0] r_mode_cmd;
    logic        r_cam_en;
    logic        r_sd_en;
    logic        r_mode_update;
    logic        r_cmd_err;
    logic        r_busy;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_shift_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_len_nxt;
    logic [15:0] w_mode_nxt;
    logic        w_check;
    logic        w_accept;
    logic        w_reject;

    // Packet verdict, evaluated during the single CHECK cycle.
    always_comb begin
        w_check  = (r_state == ST_CHECK);
        w_accept = w_check
                 && (r_byte_cnt == CMD_LEN)
                 && (r_len_q == CMD_LEN)
                 && is_known_mode(r_cmd_shift, MODE_CAM, MODE_SD);
        w_reject = w_check && !w_accept;
        if (w_accept) begin
            w_mode_nxt = r_cmd_shift;
        end else begin
            w_mode_nxt = r_mode_cmd;
        end
    end

    // FSM next state and byte-assembly datapath; a byte seen in CHECK starts
    // the next packet exactly as in IDLE so back-to-back packets lose nothing.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_cmd_shift;
        w_cnt_nxt   = r_byte_cnt;
        w_len_nxt   = r_len_q;
        case (r_state)
            ST_IDLE, ST_CHECK: begin
                if (rx.app_rx_data_valid) begin
                    w_state_nxt = ST_RECV;
                    w_shift_nxt = {8'h00, rx.app_rx_data};
                    w_cnt_nxt   = 16'd1;
                    w_len_nxt   = rx.app_rx_data_length;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rx.app_rx_data_valid) begin
                    w_shift_nxt = {r_cmd_shift[7:0], rx.app_rx_data};
                    if (r_byte_cnt != 16'hFFFF) begin
                        w_cnt_nxt = r_byte_cnt + 16'd1;
                    end else begin
                        w_cnt_nxt = r_byte_cnt;
                    end
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd_shift   <= 16'h0000;
            r_byte_cnt    <= 16'd0;
            r_len_q       <= 16'd0;
            r_mode_cmd    <= INIT_MODE;
            r_cam_en      <= (INIT_MODE == MODE_CAM);
            r_sd_en       <= (INIT_MODE == MODE_SD);
            r_mode_update <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_shift   <= w_shift_nxt;
            r_byte_cnt    <= w_cnt_nxt;
            r_len_q       <= w_len_nxt;
            r_mode_cmd    <= w_mode_nxt;
            r_cam_en      <= (w_mode_nxt == MODE_CAM);
            r_sd_en       <= (w_mode_nxt == MODE_SD);
            r_mode_update <= w_accept;
            r_cmd_err     <= w_reject;
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef MODE_RX_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;

    // Accept/reject counters, wrapping, updated on the same edge as the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_accept) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if (w_reject) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign rx_ok_cnt  = r_ok_cnt;
    assign rx_err_cnt = r_err_cnt;
`else
    assign rx_ok_cnt  = 16'd0;
    assign rx_err_cnt = 16'd0;
`endif

    assign mode_cmd    = r_mode_cmd;
    assign cam_en      = r_cam_en;
    assign sd_en       = r_sd_en;
    assign mode_update = r_mode_update;
    assign cmd_err     = r_cmd_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_udp_mode_rx.sv
// tb_udp_mode_rx: directed test-plan prefix plus randomized packet stream,
// checked every cycle against a packet-level model; reset-mid-packet at end.
module tb_udp_mode_rx;

`ifdef MODE_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int NMAX = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mode_cmd;
    logic        cam_en, sd_en, mode_update, cmd_err, busy;
    logic [15:0] rx_ok_cnt, rx_err_cnt;

    udp_mode_rx_if rx_if ();

    udp_mode_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx_if),
        .mode_cmd    (mode_cmd),
        .cam_en      (cam_en),
        .sd_en       (sd_en),
        .mode_update (mode_update),
        .cmd_err     (cmd_err),
        .busy        (busy),
        .rx_ok_cnt   (rx_ok_cnt),
        .rx_err_cnt  (rx_err_cnt)
    );

    always #5 clk = ~clk;

    // stimulus per cycle
    logic        s_v [NMAX];
    logic [7:0]  s_d [NMAX];
    logic [15:0] s_l [NMAX];
    int          n_stim = 0;

    // expected outputs after edge t
    logic [15:0] e_mode [NMAX];
    logic        e_upd  [NMAX];
    logic        e_err  [NMAX];
    logic        e_busy [NMAX];
    logic [15:0] e_ok   [NMAX];
    logic [15:0] e_ec   [NMAX];

    int n_cmp = 0;
    int n_bad = 0;

    // hand-computed checkpoints for the directed prefix
    int          lit_t    [8] = '{6, 10, 13, 18, 22, 26, 30, 33};
    logic [15:0] lit_mode [8] = '{16'h0001, 16'h0003, 16'h0003, 16'h0003,
                                  16'h0003, 16'h0003, 16'h0003, 16'h0001};
    logic        lit_upd  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        lit_err  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        lit_busy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic [7:0] d, input logic [15:0] l);
        s_v[n_stim] = v;
        s_d[n_stim] = d;
        s_l[n_stim] = l;
        n_stim++;
    endtask

    task automatic push_pkt2(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] l);
        push(1'b1, b0, l);
        push(1'b1, b1, 16'($urandom));
    endtask

    task automatic push_lows(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 8'($urandom), 16'($urandom));
    endtask

    task automatic build_stim();
        int kind, nb;
        logic [15:0] l;
        // directed prefix (indices match lit_t)
        push_lows(3);
        push_pkt2(8'h00, 8'h01, 16'd2); push_lows(2);              // A  t3,4
        push_pkt2(8'h00, 8'h03, 16'd2); push_lows(2);              // B  t7,8
        push(1'b1, 8'h00, 16'd2);       push_lows(2);              // C  t11
        push_pkt2(8'h00, 8'h03, 16'd3); push(1'b1, 8'h00, 16'd3);
        push_lows(2);                                             // D  t14-16
        push_pkt2(8'h00, 8'h02, 16'd2); push_lows(2);              // E  t19,20
        push_pkt2(8'h00, 8'h03, 16'd4); push_lows(2);              // F  t23,24
        push_pkt2(8'h00, 8'h03, 16'd2); push_lows(1);              // G  t27,28
        push_pkt2(8'h00, 8'h01, 16'd2); push_lows(2);              // H  t30,31
        // randomized stream
        while (n_stim < NMAX - 20) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: push_pkt2(8'h00, ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h03, 16'd2);
                4: push(1'b1, 8'($urandom_range(0, 3)), 16'($urandom_range(1, 2)));
                5: begin
                    nb = $urandom_range(3, 5);
                    for (int i = 0; i < nb; i++)
                        push(1'b1, 8'($urandom_range(0, 3)), 16'($urandom_range(2, 5)));
                end
                6: push_pkt2(8'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 16'd2);
                7: begin
                    l = 16'($urandom_range(0, 4));
                    push_pkt2(8'h00, 8'h03, l);
                end
                8: push_pkt2(8'($urandom), 8'($urandom), 16'($urandom_range(1, 3)));
                default: push_pkt2(8'hFF, 8'hFF, 16'd2);
            endcase
            push_lows(($urandom_range(0, 2) == 0) ? $urandom_range(2, 4) : 1);
        end
        push_lows(4);
    endtask

    // packet-level reference: a packet is a maximal run of valid bytes; its
    // verdict appears on the second edge after its last byte
    task automatic build_model();
        logic [7:0]  q[$];
        logic [15:0] rl, val, mode, okc, ecc;
        bit          pend [NMAX + 2];
        bit          pacc [NMAX + 2];
        logic [15:0] pval [NMAX + 2];
        bit          prev;
        rl = 16'd0; mode = 16'h0001; okc = 16'd0; ecc = 16'd0;
        for (int i = 0; i < NMAX + 2; i++) begin pend[i] = 1'b0; pacc[i] = 1'b0; pval[i] = 16'd0; end
        for (int t = 0; t < n_stim; t++) begin
            prev = (t > 0) ? s_v[t-1] : 1'b0;
            e_upd[t] = 1'b0;
            e_err[t] = 1'b0;
            if (pend[t]) begin
                if (pacc[t]) begin mode = pval[t]; e_upd[t] = 1'b1; okc++; end
                else begin e_err[t] = 1'b1; ecc++; end
            end
            if (s_v[t]) begin
                if (!prev) begin q.delete(); rl = s_l[t]; end
                q.push_back(s_d[t]);
            end else if (prev) begin
                if (q.size() >= 2) val = {q[q.size()-2], q[q.size()-1]};
                else val = {8'h00, q[0]};
                pend[t+1] = 1'b1;
                pval[t+1] = val;
                pacc[t+1] = (q.size() == 2) && (rl == 16'd2) && (val == 16'h0001 || val == 16'h0003);
            end
            e_mode[t] = mode;
            e_busy[t] = s_v[t] || prev;
            e_ok[t]   = STATS ? okc : 16'd0;
            e_ec[t]   = STATS ? ecc : 16'd0;
        end
    endtask

    task automatic compare(input int t);
        chk("mode_cmd", mode_cmd, e_mode[t]);
        chk("cam_en", cam_en, e_mode[t] == 16'h0001);
        chk("sd_en", sd_en, e_mode[t] == 16'h0003);
        chk("mode_update", mode_update, e_upd[t]);
        chk("cmd_err", cmd_err, e_err[t]);
        chk("busy", busy, e_busy[t]);
        chk("rx_ok_cnt", rx_ok_cnt, e_ok[t]);
        chk("rx_err_cnt", rx_err_cnt, e_ec[t]);
        for (int k = 0; k < 8; k++) begin
            if (lit_t[k] == t) begin
                chk("lit_mode", mode_cmd, lit_mode[k]);
                chk("lit_update", mode_update, lit_upd[k]);
                chk("lit_err", cmd_err, lit_err[k]);
                chk("lit_busy", busy, lit_busy[k]);
            end
        end
        if (t == 26) begin
            chk("lit_ok_cnt", rx_ok_cnt, STATS ? 16'd2 : 16'd0);
            chk("lit_err_cnt", rx_err_cnt, STATS ? 16'd4 : 16'd0);
        end
        if (t == 33) chk("lit_ok_cnt2", rx_ok_cnt, STATS ? 16'd4 : 16'd0);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [15:0] l);
        rx_if.app_rx_data_valid  = v;
        rx_if.app_rx_data        = d;
        rx_if.app_rx_data_length = l;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 16'd0);
        build_stim();
        build_model();
        repeat (3) @(negedge clk);
        chk("rst_mode", mode_cmd, 16'h0001);
        chk("rst_cam", cam_en, 1'b1);
        chk("rst_sd", sd_en, 1'b0);
        chk("rst_update", mode_update, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ok_cnt", rx_ok_cnt, 16'd0);
        chk("rst_err_cnt", rx_err_cnt, 16'd0);
        rst_n = 1'b1;
        for (int t = 0; t < n_stim; t++) begin
            drive(s_v[t], s_d[t], s_l[t]);
            @(negedge clk);
            compare(t);
        end
        // switch to SD mode, then reset during the next packet
        drive(1'b1, 8'h00, 16'd2); @(negedge clk);
        drive(1'b1, 8'h03, 16'd0); @(negedge clk);
        drive(1'b0, 8'h00, 16'd0); @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mode", mode_cmd, 16'h0003);
        chk("pre_rst_update", mode_update, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h00, 16'd2); @(negedge clk);
        chk("mid_pkt_busy", busy, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 16'd0);
        #1;
        chk("in_rst_mode", mode_cmd, 16'h0001);
        chk("in_rst_busy", busy, 1'b0);
        chk("in_rst_cam", cam_en, 1'b1);
        chk("in_rst_ok_cnt", rx_ok_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_update", mode_update, 1'b0);
            chk("post_rst_err", cmd_err, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_mode", mode_cmd, 16'h0001);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
